regfile_wb_arbiter: RTL and testbench

- Shares the single register-file write port (RegWrite / write address / write data) between two writeback requesters.
  - Source A: ALU result path.
  - Source B: load/memory result path.
- Each source has a one-entry holding slot with a valid/ready handshake.
- Arbitration is load-priority with an anti-starvation counter for A, and older-first ordering when both slots target the same register.
- Exports a per-register pending vector so decode can stall RAW hazards.

---
 rtl/rf_pkg.sv | 10 +
 rtl/regfile_wb_arbiter_if.sv | 33 +++
 rtl/wb_slot.sv | 37 +++
 rtl/regfile_wb_arbiter.sv | 96 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/rf_pkg.sv
// Shared defaults and source encoding for the register-file writeback arbiter.
package rf_pkg;

  localparam int unsigned RF_WIDTH  = 32;
  localparam int unsigned RF_ADDR_W = 5;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback requester handshakes, register-file write port and pending vector.
interface regfile_wb_arbiter_if
  import rf_pkg::*;
#(
  parameter int unsigned WIDTH  = RF_WIDTH,
  parameter int unsigned ADDR_W = RF_ADDR_W
);

  logic                     a_valid;
  logic                     a_ready;
  logic [ADDR_W-1:0]        a_rd;
  logic [WIDTH-1:0]         a_data;
  logic                     b_valid;
  logic                     b_ready;
  logic [ADDR_W-1:0]        b_rd;
  logic [WIDTH-1:0]         b_data;
  logic                     reg_write;
  logic [ADDR_W-1:0]        wr_addr;
  logic [WIDTH-1:0]         wr_data;
  logic                     grant_src;
  logic [(1<<ADDR_W)-1:0]   pending;

  modport master (
    output a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    input  a_ready, b_ready, reg_write, wr_addr, wr_data, grant_src, pending
  );

  modport slave (
    input  a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    output a_ready, b_ready, reg_write, wr_addr, wr_data, grant_src, pending
  );

endinterface

// File: rtl/wb_slot.sv
// One-entry writeback holding slot; writes to register 0 are accepted and dropped.
module wb_slot #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              drain,
  output logic              ready_c,
  output logic              fill_c,
  output logic              hv,
  output logic [ADDR_W-1:0] hrd,
  output logic [WIDTH-1:0]  hdata
);

  assign ready_c = !rst && (!hv || drain);
  assign fill_c  = in_valid && ready_c && (in_rd != '0);

  // A simultaneous accept takes precedence over the drain so the slot streams.
  always_ff @(posedge clk) begin
    if (rst) begin
      hv    <= 1'b0;
      hrd   <= '0;
      hdata <= '0;
    end else if (in_valid && ready_c) begin
      hv    <= (in_rd != '0);
      hrd   <= in_rd;
      hdata <= in_data;
    end else if (drain) begin
      hv    <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between the ALU (A) and load (B) writeback paths.
module regfile_wb_arbiter
  import rf_pkg::*;
#(
  parameter int unsigned WIDTH      = RF_WIDTH,
  parameter int unsigned ADDR_W     = RF_ADDR_W,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_wb_arbiter_if.slave  bus
);

  localparam int unsigned NREG = 1 << ADDR_W;
  localparam int unsigned SW   = $clog2(STARVE_MAX + 1);

  logic              hv_a, hv_b, fill_a, fill_b, ready_a, ready_b;
  logic [ADDR_W-1:0] hrd_a, hrd_b;
  logic [WIDTH-1:0]  hdata_a, hdata_b;
  logic              sel_a_c, sel_b_c;
  logic              age;
  logic [SW-1:0]     starve;
  logic [NREG-1:0]   pending_c;
  logic              reg_write, grant_src;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;

  wb_slot #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_slot_a (
    .clk(clk), .rst(rst), .in_valid(bus.a_valid), .in_rd(bus.a_rd), .in_data(bus.a_data),
    .drain(sel_a_c), .ready_c(ready_a), .fill_c(fill_a), .hv(hv_a), .hrd(hrd_a), .hdata(hdata_a)
  );

  wb_slot #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_slot_b (
    .clk(clk), .rst(rst), .in_valid(bus.b_valid), .in_rd(bus.b_rd), .in_data(bus.b_data),
    .drain(sel_b_c), .ready_c(ready_b), .fill_c(fill_b), .hv(hv_b), .hrd(hrd_b), .hdata(hdata_b)
  );

  // Same destination keeps program order; otherwise loads win unless A has starved.
  always_comb begin
    sel_a_c = 1'b0;
    sel_b_c = 1'b0;
    if (hv_a && hv_b) begin
      if (hrd_a == hrd_b)                    sel_b_c = age;
      else if (starve == SW'(STARVE_MAX))    sel_b_c = 1'b0;
      else                                   sel_b_c = 1'b1;
      sel_a_c = !sel_b_c;
    end else begin
      sel_a_c = hv_a;
      sel_b_c = hv_b;
    end
  end

  // A fill makes that slot the newer one; a joint fill leaves B older.
  always_ff @(posedge clk) begin
    if (rst)         age <= 1'b0;
    else if (fill_a) age <= 1'b1;
    else if (fill_b) age <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst || !hv_a || sel_a_c)            starve <= '0;
    else if (starve != SW'(STARVE_MAX))     starve <= starve + SW'(1);
  end

  // Address and data hold their last values across idle cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      grant_src <= SRC_A;
    end else if (sel_a_c || sel_b_c) begin
      reg_write <= 1'b1;
      wr_addr   <= sel_b_c ? hrd_b : hrd_a;
      wr_data   <= sel_b_c ? hdata_b : hdata_a;
      grant_src <= sel_b_c ? SRC_B : SRC_A;
    end else begin
      reg_write <= 1'b0;
    end
  end

  always_comb begin
    pending_c = '0;
    if (hv_a) pending_c[hrd_a] = 1'b1;
    if (hv_b) pending_c[hrd_b] = 1'b1;
  end

  assign bus.a_ready   = ready_a;
  assign bus.b_ready   = ready_b;
  assign bus.reg_write = reg_write;
  assign bus.wr_addr   = wr_addr;
  assign bus.wr_data   = wr_data;
  assign bus.grant_src = grant_src;
  assign bus.pending   = pending_c;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter.
module tb_regfile_wb_arbiter;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned NREG   = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [WIDTH-1:0] rf_model [NREG];

  regfile_wb_arbiter_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

  regfile_wb_arbiter #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .STARVE_MAX(3)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  // Register-file image built from the write port, used for final-value checks.
  always @(posedge clk) begin
    if (bus.reg_write) rf_model[bus.wr_addr] <= bus.wr_data;
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.a_valid = 1'b0; bus.a_rd = '0; bus.a_data = '0;
    bus.b_valid = 1'b0; bus.b_rd = '0; bus.b_data = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step(); step();
    checks++; if (bus.reg_write !== 1'b0) begin errors++; $display("FAIL rst_reg_write got %0h want 0", bus.reg_write); end
    checks++; if (bus.wr_addr !== '0) begin errors++; $display("FAIL rst_wr_addr got %0h want 0", bus.wr_addr); end
    checks++; if (bus.wr_data !== '0) begin errors++; $display("FAIL rst_wr_data got %0h want 0", bus.wr_data); end
    checks++; if (bus.grant_src !== 1'b0) begin errors++; $display("FAIL rst_grant_src got %0h want 0", bus.grant_src); end
    checks++; if (bus.pending !== '0) begin errors++; $display("FAIL rst_pending got %0h want 0", bus.pending); end
    bus.a_valid = 1'b1; bus.a_rd = 5'd3; bus.b_valid = 1'b1; bus.b_rd = 5'd4;
    #1;
    checks++; if (bus.a_ready !== 1'b0) begin errors++; $display("FAIL rst_a_ready got %0h want 0", bus.a_ready); end
    checks++; if (bus.b_ready !== 1'b0) begin errors++; $display("FAIL rst_b_ready got %0h want 0", bus.b_ready); end
    step();
    idle_inputs();
    rst = 1'b0;
    #1;
    checks++; if (bus.pending !== '0) begin errors++; $display("FAIL rst_no_accept got %0h want 0", bus.pending); end
    step();
  endtask

  task automatic test_single_a();
    bus.a_valid = 1'b1; bus.a_rd = 5'd5; bus.a_data = 32'hAAAA_0005;
    #1;
    checks++; if (bus.a_ready !== 1'b1) begin errors++; $display("FAIL single_a_ready got %0h want 1", bus.a_ready); end
    step();
    idle_inputs();
    checks++; if (bus.pending !== 32'h0000_0020) begin errors++; $display("FAIL single_pending got %0h want 20", bus.pending); end
    checks++; if (bus.reg_write !== 1'b0) begin errors++; $display("FAIL single_early_write got %0h want 0", bus.reg_write); end
    step();
    checks++; if (bus.reg_write !== 1'b1) begin errors++; $display("FAIL single_reg_write got %0h want 1", bus.reg_write); end
    checks++; if (bus.wr_addr !== 5'd5) begin errors++; $display("FAIL single_wr_addr got %0h want 5", bus.wr_addr); end
    checks++; if (bus.wr_data !== 32'hAAAA_0005) begin errors++; $display("FAIL single_wr_data got %0h want aaaa0005", bus.wr_data); end
    checks++; if (bus.grant_src !== 1'b0) begin errors++; $display("FAIL single_grant got %0h want 0", bus.grant_src); end
    checks++; if (bus.pending !== '0) begin errors++; $display("FAIL single_pending_clear got %0h want 0", bus.pending); end
    step();
    checks++; if (bus.reg_write !== 1'b0) begin errors++; $display("FAIL single_idle got %0h want 0", bus.reg_write); end
    checks++; if (bus.wr_addr !== 5'd5) begin errors++; $display("FAIL single_addr_hold got %0h want 5", bus.wr_addr); end
  endtask

  task automatic test_x0_drop();
    bus.b_valid = 1'b1; bus.b_rd = 5'd0; bus.b_data = 32'hDEAD_BEEF;
    #1;
    checks++; if (bus.b_ready !== 1'b1) begin errors++; $display("FAIL x0_b_ready got %0h want 1", bus.b_ready); end
    step();
    idle_inputs();
    checks++; if (bus.pending !== '0) begin errors++; $display("FAIL x0_pending got %0h want 0", bus.pending); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.reg_write !== 1'b0) begin errors++; $display("FAIL x0_reg_write cyc %0d got %0h want 0", i, bus.reg_write); end
      step();
    end
  endtask

  task automatic test_same_rd();
    // B then A on consecutive edges
    bus.b_valid = 1'b1; bus.b_rd = 5'd7; bus.b_data = 32'd1;
    step();
    idle_inputs();
    bus.a_valid = 1'b1; bus.a_rd = 5'd7; bus.a_data = 32'd2;
    #1;
    checks++; if (bus.a_ready !== 1'b1) begin errors++; $display("FAIL seq_a_ready got %0h want 1", bus.a_ready); end
    step();
    idle_inputs();
    checks++; if (bus.reg_write !== 1'b1 || bus.wr_data !== 32'd1 || bus.grant_src !== 1'b1)
      begin errors++; $display("FAIL seq_first got we=%0h d=%0h src=%0h want we=1 d=1 src=1", bus.reg_write, bus.wr_data, bus.grant_src); end
    step();
    checks++; if (bus.reg_write !== 1'b1 || bus.wr_data !== 32'd2 || bus.grant_src !== 1'b0)
      begin errors++; $display("FAIL seq_second got we=%0h d=%0h src=%0h want we=1 d=2 src=0", bus.reg_write, bus.wr_data, bus.grant_src); end
    step();
    checks++; if (rf_model[7] !== 32'd2) begin errors++; $display("FAIL seq_r7 got %0h want 2", rf_model[7]); end
    // both on the same edge: B is older
    bus.a_valid = 1'b1; bus.a_rd = 5'd7; bus.a_data = 32'd3;
    bus.b_valid = 1'b1; bus.b_rd = 5'd7; bus.b_data = 32'd4;
    step();
    idle_inputs();
    checks++; if (bus.pending !== 32'h0000_0080) begin errors++; $display("FAIL same_pending got %0h want 80", bus.pending); end
    step();
    checks++; if (bus.reg_write !== 1'b1 || bus.wr_data !== 32'd4 || bus.grant_src !== 1'b1)
      begin errors++; $display("FAIL same_first got we=%0h d=%0h src=%0h want we=1 d=4 src=1", bus.reg_write, bus.wr_data, bus.grant_src); end
    step();
    checks++; if (bus.reg_write !== 1'b1 || bus.wr_data !== 32'd3 || bus.grant_src !== 1'b0)
      begin errors++; $display("FAIL same_second got we=%0h d=%0h src=%0h want we=1 d=3 src=0", bus.reg_write, bus.wr_data, bus.grant_src); end
    step();
    checks++; if (rf_model[7] !== 32'd3) begin errors++; $display("FAIL same_r7 got %0h want 3", rf_model[7]); end
  endtask

  task automatic test_starve();
    logic [7:0] exp_grant;
    exp_grant = 8'b0111_0111;
    bus.a_valid = 1'b1; bus.a_rd = 5'd10; bus.a_data = 32'hA000_000A;
    bus.b_valid = 1'b1; bus.b_rd = 5'd11; bus.b_data = 32'hB000_000B;
    step();
    checks++; if (bus.reg_write !== 1'b0) begin errors++; $display("FAIL starve_first_cycle got %0h want 0", bus.reg_write); end
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (bus.reg_write !== 1'b1 || bus.grant_src !== exp_grant[i] ||
          bus.wr_addr !== (exp_grant[i] ? 5'd11 : 5'd10)) begin
        errors++;
        $display("FAIL starve_write %0d got we=%0h src=%0h addr=%0d want we=1 src=%0h", i,
                 bus.reg_write, bus.grant_src, bus.wr_addr, exp_grant[i]);
      end
    end
    idle_inputs();
    step(); step(); step(); step();
    checks++; if (bus.pending !== '0 || bus.reg_write !== 1'b0)
      begin errors++; $display("FAIL starve_drain got pend=%0h we=%0h want 0 0", bus.pending, bus.reg_write); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin
        bus.b_valid = 1'b1; bus.b_rd = 5'(i + 1); bus.b_data = 32'hB000_0000 | 32'(i + 1);
        #1;
        checks++; if (bus.b_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready %0d got %0h want 1", i, bus.b_ready); end
      end else begin
        idle_inputs();
      end
      if (i >= 2) begin
        checks++;
        if (bus.reg_write !== 1'b1 || bus.wr_addr !== 5'(i - 1) || bus.wr_data !== (32'hB000_0000 | 32'(i - 1))) begin
          errors++;
          $display("FAIL b2b_write %0d got we=%0h addr=%0d data=%0h want we=1 addr=%0d", i,
                   bus.reg_write, bus.wr_addr, bus.wr_data, i - 1);
        end
      end else begin
        checks++; if (bus.reg_write !== 1'b0) begin errors++; $display("FAIL b2b_lead %0d got %0h want 0", i, bus.reg_write); end
      end
      step();
    end
    checks++; if (bus.reg_write !== 1'b0) begin errors++; $display("FAIL b2b_tail got %0h want 0", bus.reg_write); end
  endtask

  task automatic test_reset_mid();
    bus.a_valid = 1'b1; bus.a_rd = 5'd12; bus.a_data = 32'h1212_1212;
    bus.b_valid = 1'b1; bus.b_rd = 5'd13; bus.b_data = 32'h1313_1313;
    step();
    idle_inputs();
    checks++; if (bus.pending !== 32'h0000_3000) begin errors++; $display("FAIL mid_pending got %0h want 3000", bus.pending); end
    rst = 1'b1;
    #1;
    checks++; if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0)
      begin errors++; $display("FAIL mid_ready got a=%0h b=%0h want 0 0", bus.a_ready, bus.b_ready); end
    step();
    rst = 1'b0;
    checks++; if (bus.reg_write !== 1'b0) begin errors++; $display("FAIL mid_reg_write got %0h want 0", bus.reg_write); end
    checks++; if (bus.pending !== '0) begin errors++; $display("FAIL mid_pending_clear got %0h want 0", bus.pending); end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (bus.reg_write !== 1'b0) begin errors++; $display("FAIL mid_ghost %0d got %0h want 0", i, bus.reg_write); end
    end
  endtask

  initial begin
    test_reset();
    test_single_a();
    test_x0_drop();
    test_same_rd();
    test_starve();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
